// File: rtl/ones_stream_tx.sv
// Serial MSB-first word transmitter with a mod-3 count of transmitted '1' bits.
// 'tick' flags every third '1' in the same cycle that bit is on 'out'.
module ones_stream_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              out,
  output logic              out_valid,
  output logic              tick,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(DATA_W - 1);
  localparam logic [3:0] GAP_LD   = 4'((GAP > 0) ? (GAP - 1) : 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [3:0]        gapcnt_q, gapcnt_d;
  logic [1:0]        ones_q, ones_d;
  logic              done_q, done_d;

  // The unreachable count value 3 is folded onto 0 before advancing.
  function automatic logic [1:0] ones_next(input logic [1:0] cur, input logic one_sent);
    logic [1:0] base;
    base = (cur == 2'd3) ? 2'd0 : cur;
    if (!one_sent)
      return base;
    return (base == 2'd2) ? 2'd0 : base + 2'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    gapcnt_d   = gapcnt_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d  = load_data;
          bitcnt_d = LAST_IDX;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d  = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd0) begin
          done_d   = 1'b1;
          bitcnt_d = 5'd0;
          if (GAP > 0) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gapcnt_q == 4'd0)
          state_d = S_IDLE;
        else
          gapcnt_d = gapcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out    = out_valid & shreg_q[DATA_W-1];
  assign tick   = out_valid & out & (ones_q == 2'd2);
  assign done   = done_q;
  assign ones_d = ones_next(ones_q, out_valid & out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      ones_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      ones_q   <= ones_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ones_stream_tx.sv
// Scoreboard bench for ones_stream_tx (DATA_W=8, GAP=1): expected bits/ticks are
// queued when a word is offered and popped as the serial stream appears.
module tb_ones_stream_tx;

  localparam int DW = 8;
  localparam int GP = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          out, out_valid, tick, busy, done;

  ones_stream_tx #(.DATA_W(DW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .out(out), .out_valid(out_valid), .tick(tick),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ones = 0;
  int   bit_idx = 0;
  int   idle_run = 0;
  int   ready_run = 0;
  int   n_ticks = 0;
  logic exp_done = 1'b0;
  logic prev_vld = 1'b0;
  bit   seen_burst = 1'b0;
  bit   gap_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      bit_idx    = 0;
      exp_done   = 1'b0;
      prev_vld   = 1'b0;
      idle_run   = 0;
      ready_run  = 0;
      seen_burst = 1'b0;
    end else begin
      check_eq("done", done, exp_done);
      exp_done = 1'b0;
      check_eq("ready_vs_busy", load_ready, !busy);
      if (out_valid) begin
        if (!prev_vld && gap_en && seen_burst) begin
          check_eq("burst_gap", idle_run, 2);
          check_eq("ready_pulse", ready_run, 1);
        end
        if (sb.size() == 0) begin
          check_eq("unexpected_bit", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("out", out, e.b);
          check_eq("tick", tick, e.t);
        end
        if (tick) n_ticks++;
        bit_idx++;
        if (bit_idx == DW) begin
          bit_idx    = 0;
          exp_done   = 1'b1;
          seen_burst = gap_en;
        end
        idle_run  = 0;
        ready_run = 0;
      end else begin
        check_eq("out_idle", {out, tick}, 0);
        idle_run++;
        if (load_ready) ready_run++;
      end
      prev_vld = out_valid;
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    exp_t x;
    for (int i = DW - 1; i >= 0; i--) begin
      x.b = d[i];
      x.t = d[i] && (m_ones == 2);
      if (d[i]) m_ones = (m_ones + 1) % 3;
      sb.push_back(x);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    load_valid = 1'b0;
    sb.delete();
    m_ones = 0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ready", load_ready, 1);
    check_eq("rst_outs", {out, out_valid, tick, busy, done}, 0);
    rst = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit keep);
    bit hs = 1'b0;
    int k  = 0;
    load_data  = d;
    load_valid = 1'b1;
    push_word(d);
    while (!hs && k < 60) begin
      hs = load_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!hs) check_eq("handshake_timeout", 0, 1);
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || !load_ready) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) check_eq("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset hold, then asynchronous reset in the middle of a word
    do_reset();
    send(8'hFF, 1'b0);
    k = 0;
    while (bit_idx < 3 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("reached_bit3", bit_idx, 3);
    #1;
    rst = 1'b0;
    #1;
    check_eq("async_rst_vld", out_valid, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_ready", load_ready, 1);
    sb.delete();
    m_ones = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    n_ticks = 0;
    send(8'hE0, 1'b0);
    wait_idle();
    check_eq("post_rst_ticks", n_ticks, 1);

    // A5 from reset: tick on the 6th bit only
    do_reset();
    n_ticks = 0;
    send(8'hA5, 1'b0);
    wait_idle();
    check_eq("a5_ticks", n_ticks, 1);

    // FF twice: ticks span the word boundary
    do_reset();
    n_ticks = 0;
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    wait_idle();
    check_eq("ff_ff_ticks", n_ticks, 5);

    // All-zero word holds the count; the following C0 ticks on its 2nd '1'
    n_ticks = 0;
    send(8'h00, 1'b0);
    wait_idle();
    check_eq("zero_ticks", n_ticks, 0);
    send(8'hC0, 1'b0);
    wait_idle();
    check_eq("c0_ticks", n_ticks, 1);

    // Back-to-back words with load_valid held high
    gap_en = 1'b1;
    send(8'h3C, 1'b1);
    send(8'h81, 1'b1);
    send(8'hC3, 1'b1);
    load_valid = 1'b0;
    wait_idle();
    gap_en = 1'b0;

    // load_valid pulsed mid-word must not disturb the word in flight
    send(8'h96, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    load_data  = 8'h5A;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle();

    check_eq("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
